// File: rtl/temp_state_classifier.sv
// temp_state_classifier
// Sorts validated temperature samples into display classes and debounces the
// class with a persistence counter. The committed class drives the 7-segment
// display. A watchdog drops the output back to "no data" when samples stop.

module temp_state_classifier #(
    parameter int T_LOW     = 35,
    parameter int T_BODY_HI = 38,
    parameter int T_EXT     = 60,
    parameter int PERSIST   = 4,
    parameter int TIMEOUT   = 50_000_000,
    parameter int TO_W      = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    output logic [2:0] actual_state,
    output logic       state_change,
    output logic       alarm
);

    // Class codes exactly as the display expects them
    typedef enum logic [2:0] {
        ST_NODATA = 3'd0,
        ST_L      = 3'd1,
        ST_H      = 3'd2,
        ST_P      = 3'd3,
        ST_C      = 3'd4
    } tempClass_e;

    // Control mode is derived from the committed class, not stored separately
    typedef enum logic {
        MODE_NODATA = 1'b0,
        MODE_TRACK  = 1'b1
    } mode_e;

    localparam logic [7:0]      T_LOW_C      = 8'(T_LOW);
    localparam logic [7:0]      T_BODY_HI_C  = 8'(T_BODY_HI);
    localparam logic [7:0]      T_EXT_C      = 8'(T_EXT);
    localparam logic [3:0]      PERSIST_LAST = 4'(PERSIST - 1);
    localparam logic [TO_W-1:0] TO_MAX       = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE       = TO_W'(1);

    tempClass_e      actualState_q, actualState_d;
    tempClass_e      cand_q, cand_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [TO_W-1:0] toCnt_q, toCnt_d;
    logic            stateChange_q;
    logic            alarm_q;

    tempClass_e      sampleClass;
    mode_e           mode;
    logic            timeoutHit;

    // Map the incoming temperature onto its class (unsigned 8-bit compares)
    always_comb begin
        sampleClass = ST_P;
        if (temp < T_LOW_C) begin
            sampleClass = ST_L;
        end else if (temp <= T_BODY_HI_C) begin
            sampleClass = ST_C;
        end else if (temp < T_EXT_C) begin
            sampleClass = ST_H;
        end
    end

    // Watchdog counter: cleared by each sample, saturating one below the limit
    always_comb begin
        toCnt_d    = toCnt_q;
        timeoutHit = 1'b0;
        if (temp_valid) begin
            toCnt_d = '0;
        end else if (toCnt_q == TO_MAX) begin
            timeoutHit = 1'b1;
        end else begin
            toCnt_d = toCnt_q + TO_ONE;
        end
    end

    // Next committed class, candidate and persistence count; a sample always beats the watchdog
    always_comb begin
        actualState_d = actualState_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        mode          = (actualState_q == ST_NODATA) ? MODE_NODATA : MODE_TRACK;
        if (temp_valid) begin
            if (mode == MODE_NODATA) begin
                actualState_d = sampleClass;
                cand_d        = sampleClass;
                cnt_d         = 4'd0;
            end else if (sampleClass == actualState_q) begin
                cand_d = sampleClass;
                cnt_d  = 4'd0;
            end else if (sampleClass == cand_q) begin
                if (cnt_q == PERSIST_LAST) begin
                    actualState_d = sampleClass;
                    cnt_d         = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cand_d = sampleClass;
                cnt_d  = 4'd1;
                if (PERSIST == 1) begin
                    actualState_d = sampleClass;
                end
            end
        end else if (timeoutHit) begin
            actualState_d = ST_NODATA;
            cand_d        = ST_NODATA;
            cnt_d         = 4'd0;
        end
    end

    // State register plus registered change pulse and alarm flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            actualState_q <= ST_NODATA;
            cand_q        <= ST_NODATA;
            cnt_q         <= 4'd0;
            toCnt_q       <= '0;
            stateChange_q <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            actualState_q <= actualState_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            toCnt_q       <= toCnt_d;
            stateChange_q <= (actualState_d != actualState_q);
            alarm_q       <= (actualState_d == ST_P);
        end
    end

    assign actual_state = actualState_q;
    assign state_change = stateChange_q;
    assign alarm        = alarm_q;

endmodule
